// File: rtl/led_feedback_n_if.sv
// Vend-controller to front-panel LED driver bundle: FSM state, event pulses, stock flags, LED lanes.
// master = vend controller side, slave = LED driver side.
interface led_feedback_n_if #(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = 2,
  parameter int PWM_BITS  = 4
);
  logic [2:0]             state;
  logic                   vend_event;
  logic                   error_event;
  logic                   change_returning;
  logic [7:0]             change_due;
  logic [NUM_ITEMS-1:0]   stock_available;
  logic [NUM_ITEMS-1:0]   low_stock;
  logic [SEL_W-1:0]       item_select;
  logic [PWM_BITS-1:0]    brightness;
  logic [2*NUM_ITEMS-1:0] leds;

  modport master (
    output state, vend_event, error_event, change_returning, change_due,
    output stock_available, low_stock, item_select, brightness,
    input  leds
  );

  modport slave (
    input  state, vend_event, error_event, change_returning, change_due,
    input  stock_available, low_stock, item_select, brightness,
    output leds
  );
endinterface

// File: rtl/led_feedback_n.sv
// Front-panel LED driver: stock lanes, vend animation, error blink, change display, PWM dimming.
// One clk from inputs to registered leds; no backpressure, inputs are sampled every cycle.
module led_feedback_n #(
  parameter int NUM_ITEMS   = 4,
  parameter int SEL_W       = 2,
  parameter int TICK_DIV    = 12_000_000,
  parameter int ANIM_TICKS  = 6,
  parameter int ERROR_TICKS = 8,
  parameter int ANIM_MODE   = 0,
  parameter int PWM_BITS    = 4
) (
  input  logic             clk,
  input  logic             rst,
  led_feedback_n_if.slave  bus
);
  localparam int               TW        = $clog2(TICK_DIV);
  localparam int               LW        = 2 * NUM_ITEMS;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] LANE_LAST = SEL_W'(NUM_ITEMS - 1);
  localparam logic [2:0]       ST_CHANGE = 3'd4;
  localparam logic [2:0]       ST_THANK  = 3'd6;
  localparam logic             DIR_UP    = 1'b1;
  localparam logic             DIR_DOWN  = 1'b0;

  logic [TW-1:0]        tick_cnt;
  logic                 blink_phase;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 anim_active;
  logic [7:0]           anim_timer;
  logic [NUM_ITEMS-1:0] anim_pattern;
  logic                 anim_dir;
  logic [7:0]           error_timer;

  logic                 slow_tick;
  logic [SEL_W-1:0]     sel_lane;
  logic [NUM_ITEMS-1:0] load_pattern;
  logic [NUM_ITEMS-1:0] step_pattern;
  logic                 step_dir;
  logic                 move_up;
  logic [NUM_ITEMS-1:0] stock_lanes;
  logic [NUM_ITEMS-1:0] status_lanes;
  logic [NUM_ITEMS-1:0] change_lanes;
  logic                 show_change;
  logic                 pwm_on;

  if (NUM_ITEMS <= 8) begin : g_chg_narrow
    assign change_lanes = bus.change_due[NUM_ITEMS-1:0];
  end else begin : g_chg_wide
    assign change_lanes = {{(NUM_ITEMS-8){1'b0}}, bus.change_due};
  end

  always_comb begin
    slow_tick    = (tick_cnt == TICK_LAST);
    sel_lane     = (bus.item_select > LANE_LAST) ? LANE_LAST : bus.item_select;
    load_pattern = NUM_ITEMS'(1) << sel_lane;

    // Bounce: a lane already at the end it is heading for reverses instead of falling off.
    move_up = (anim_dir == DIR_UP) ? ~anim_pattern[NUM_ITEMS-1] : anim_pattern[0];
    if (ANIM_MODE == 0) begin
      step_pattern = {anim_pattern[NUM_ITEMS-2:0], anim_pattern[NUM_ITEMS-1]};
      step_dir     = anim_dir;
    end else begin
      step_pattern = move_up ? (anim_pattern << 1) : (anim_pattern >> 1);
      if (step_pattern[NUM_ITEMS-1])
        step_dir = DIR_DOWN;
      else if (step_pattern[0])
        step_dir = DIR_UP;
      else
        step_dir = move_up ? DIR_UP : DIR_DOWN;
    end

    stock_lanes = bus.stock_available & (~bus.low_stock | {NUM_ITEMS{blink_phase}});
    show_change = bus.change_returning |
                  (((bus.state == ST_CHANGE) | (bus.state == ST_THANK)) & (bus.change_due != 8'd0));

    if (error_timer != 8'd0)
      status_lanes = {NUM_ITEMS{blink_phase}};
    else if (anim_active)
      status_lanes = anim_pattern;
    else if (show_change)
      status_lanes = change_lanes;
    else
      status_lanes = '0;

    pwm_on = (bus.brightness == '1) | (pwm_cnt < bus.brightness);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.leds     <= '0;
      tick_cnt     <= '0;
      blink_phase  <= 1'b0;
      pwm_cnt      <= '0;
      anim_active  <= 1'b0;
      anim_timer   <= 8'd0;
      anim_pattern <= NUM_ITEMS'(1);
      anim_dir     <= DIR_UP;
      error_timer  <= 8'd0;
    end else begin
      tick_cnt <= slow_tick ? '0 : tick_cnt + TW'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      if (slow_tick)
        blink_phase <= ~blink_phase;

      if (bus.error_event)
        error_timer <= 8'(ERROR_TICKS);
      else if (slow_tick && (error_timer != 8'd0))
        error_timer <= error_timer - 8'd1;

      if (bus.vend_event) begin
        anim_active  <= 1'b1;
        anim_timer   <= 8'(ANIM_TICKS);
        anim_pattern <= load_pattern;
        anim_dir     <= DIR_UP;
      end else if (slow_tick && anim_active) begin
        if (anim_timer == 8'd0) begin
          anim_active <= 1'b0;
        end else begin
          anim_timer   <= anim_timer - 8'd1;
          anim_pattern <= step_pattern;
          anim_dir     <= step_dir;
        end
      end

      bus.leds <= {status_lanes, stock_lanes} & {LW{pwm_on}};
    end
  end
endmodule

// File: doc/led_feedback_n.md
Name: led_feedback_n

Overview:
- Parametrised successor LED driver for the vending front panel.
- Drives NUM_ITEMS stock lanes and NUM_ITEMS status lanes, with low-stock blinking, a selectable vend animation (rotate or bounce), error blinking, change display and global PWM brightness.
- Sits beside the vend controller FSM and consumes its state code and event pulses.
- Output is registered.

Parameters:
- NUM_ITEMS, 4, item count; leds width = 2*NUM_ITEMS; NUM_ITEMS >= 2.
- SEL_W, 2, width of item_select; 2**SEL_W >= NUM_ITEMS.
- TICK_DIV, 12_000_000, clk cycles per slow tick; >= 2.
- ANIM_TICKS, 6, slow ticks of vend animation after load; 1..255.
- ERROR_TICKS, 8, slow ticks of error blinking; 1..255.
- ANIM_MODE, 0, 0 = rotate toward MSB with wrap; 1 = bounce between lane 0 and lane NUM_ITEMS-1.
- PWM_BITS, 4, brightness resolution.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- state  in  3  vend FSM state code; CHANGE = 3'd4, THANK = 3'd6
- vend_event  in  1  one-cycle pulse, item dispensed
- error_event  in  1  one-cycle pulse, error occurred
- change_returning  in  1  change is being returned
- change_due  in  8  change amount
- stock_available  in  NUM_ITEMS  1 = item in stock
- low_stock  in  NUM_ITEMS  1 = item below restock threshold
- item_select  in  SEL_W  selected item index
- brightness  in  PWM_BITS  0 = dark, all-ones = full on
- leds  out  2*NUM_ITEMS  [NUM_ITEMS-1:0] stock lanes, [2*NUM_ITEMS-1:NUM_ITEMS] status lanes

Behaviour:
- All state is updated on posedge clk. rst is synchronous and active-high. rst has priority over every event, including reset in the middle of an animation or error blink.
- Reset values:
  - leds = 0
  - tick_cnt = 0
  - blink_phase = 0
  - pwm_cnt = 0
  - anim_active = 0, anim_timer = 0, anim_pattern = one-hot lane 0, anim_dir = up
  - error_timer = 0
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - slow_tick is asserted combinationally when tick_cnt == TICK_DIV-1, so it is high for one cycle every TICK_DIV cycles.
  - blink_phase toggles on every slow_tick.
- Stock lanes: lane i = stock_available[i] & (~low_stock[i] | blink_phase). Low-stock items blink; out-of-stock items stay dark.
- Error timer:
  - error_event loads error_timer = ERROR_TICKS. A load during an active blink restarts the count.
  - Otherwise, on slow_tick, error_timer decrements while nonzero.
- Animation:
  - vend_event sets anim_active = 1, anim_timer = ANIM_TICKS, anim_pattern = one-hot at item_select, anim_dir = up. item_select >= NUM_ITEMS clamps to lane NUM_ITEMS-1. A load during an active animation restarts it.
  - Otherwise, on slow_tick while anim_active:
    - If anim_timer == 0, clear anim_active.
    - Else decrement anim_timer and step the pattern.
  - Step in mode 0: rotate left, MSB wraps to lane 0.
  - Step in mode 1: move one lane in anim_dir. When the step lands on lane NUM_ITEMS-1 or lane 0, flip anim_dir.
- Simultaneous vend_event and error_event: both load. The animation runs hidden under the error display and is shown if it outlives the error.
- Status-lane priority, highest first:
  1. error_timer != 0: all ones if blink_phase, else 0.
  2. anim_active: anim_pattern.
  3. change_returning, or (state == CHANGE or THANK) and change_due != 0: change_due[NUM_ITEMS-1:0]; zero-extended if NUM_ITEMS > 8.
  4. Otherwise 0.
- PWM:
  - pwm_cnt increments every clk and wraps.
  - pwm_on = (brightness == all-ones) | (pwm_cnt < brightness).
- Output: leds <= composed value & {2*NUM_ITEMS{pwm_on}}. Latency is one clk from inputs to leds.
- Widths: timers are 8 bits wide. The prescaler is $clog2(TICK_DIV) bits wide. All comparisons are unsigned.

Test Plan:
- Common settings: TICK_DIV = 4, NUM_ITEMS = 4, brightness = 4'hF unless stated.
- Reset: assert rst for 3 cycles in the middle of an animation -> leds = 0 on the next edge; timers cleared; anim_active = 0.
- Stock/low-stock: stock_available = 4'b1011, low_stock = 4'b0010 -> leds[3:0] alternates between 4'b1001 and 4'b1011 every 4 clk; leds[7:4] = 0.
- Vend, rotate mode: item_select = 2, vend_event -> leds[7:4] = 0100, 1000, 0001, 0010, ... changing on each slow_tick for 6 steps, then 0.
- Vend, bounce mode (ANIM_MODE = 1): item_select = 3 -> 1000, 0100, 0010, 0001, 0010, 0100, 1000, then 0. Also item_select clamp check with NUM_ITEMS = 3, SEL_W = 2, item_select = 3 -> starts at lane 2.
- Priority: error_event and vend_event in the same cycle, with state = 6 and change_due = 8'h05:
  - error blinks 1111/0000 for 8 ticks;
  - the animation is fully expired before the error ends, so no animation is visible;
  - then leds[7:4] = 0101.
  - Repeat with ERROR_TICKS = 2 -> the animation is visible after the error ends.
- PWM: brightness = 4 with a steady lane -> lane high for exactly 4 of every 16 clk; brightness = 0 -> leds = 0 always.
